// File: rtl/md_sched_pkg.sv
// md_sched_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op_e : md opcode encoding, shared with the controller decoder
//   - MULT_LAT_DEF / DIV_LAT_DEF : default busy latencies
//   - md_state_e : sequencer FSM states
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for the four ops that occupy the unit for a latency window.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched_alu.sv
// md_alu: combinational multiply/divide datapath.
//   op     in  3   md opcode
//   a, b   in  32  operands (rs, rt)
//   result out 64  {hi, lo}: product, or {remainder, quotient}
// Divide by zero returns lo=all-ones, hi=dividend. The signed overflow case
// 0x80000000 / -1 returns quotient 0x80000000, remainder 0.
module md_alu
    import md_sched_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] dvsr;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Substituting a divisor of 1 keeps the dividers well defined for the
    // zero and overflow cases; /1 also yields exactly the overflow result.
    assign dvsr   = (div_zero || div_ovf) ? 32'd1 : b;
    assign quot_s = $signed(a) / $signed(dvsr);
    assign rem_s  = $signed(a) % $signed(dvsr);
    assign quot_u = a / dvsr;
    assign rem_u  = a % dvsr;

    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = div_zero ? {a, 32'hFFFF_FFFF} : {rem_s, quot_s};
            MD_DIVU:  result = div_zero ? {a, 32'hFFFF_FFFF} : {rem_u, quot_u};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer for the 5-stage pipeline.
//   clk, rst   clock, synchronous active-high reset
//   start      EX-stage md instruction valid
//   op         md opcode (md_op_e)
//   a, b       forwarded rs/rt operands, sampled only at the start edge
//   id_md      ID-stage instruction touches the md unit
//   hi, lo     architectural HI/LO registers
//   busy       unit occupied by mult/div
//   stall      structural stall request to the hazard controller
// The result is computed at the start edge and held in a pending register;
// it is committed to HI/LO when the latency counter expires.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CW       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        id_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    md_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [63:0]    pend_q;
    logic [31:0]    hi_q, lo_q;
    logic [63:0]    alu_result;
    logic           launch;

    md_alu u_alu (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (alu_result)
    );

    assign launch = (state_q == ST_IDLE) && start && is_arith(op);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch)          state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == '0)     state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == ST_BUSY);
    end

    // Counter, pending result and HI/LO. Starts arriving while BUSY fall
    // through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            if (launch) begin
                pend_q <= alu_result;
                cnt_q  <= ((op == MD_MULT) || (op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
            end else if (start && (op == MD_MTHI)) begin
                hi_q <= a;
            end else if (start && (op == MD_MTLO)) begin
                lo_q <= a;
            end
        end else begin
            if (cnt_q == '0) begin
                {hi_q, lo_q} <= pend_q;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    // The launching start counts too, so an md op in ID cannot slip past
    // a mult/div that is entering the unit this very cycle.
    assign stall = id_md && (busy || (start && is_arith(op)));

endmodule

// File: tb/tb_md_sched.sv
// Directed testbench for md_sched: reset, mult/multu/div/divu latencies and
// results, divide special cases, stall behaviour, mthi/mtlo, back-to-back
// issue and reset abort.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        id_md;
    logic [31:0] hi, lo;
    logic        busy, stall;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] m_hi, m_lo;   // expected architectural HI/LO

    md_sched #(.MULT_LAT(5), .DIV_LAT(10), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .id_md (id_md),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .stall (stall)
    );

    always #5 clk = ~clk;

    // The hazard controller must never issue a start while the unit is busy.
    always @(negedge clk) begin
        if (!rst && start && busy) begin
            n_mis++;
            $error("FAIL start_while_busy observed=1 expected=0");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div, check busy/stall through the latency window while
    // scrambling operands, then check the committed HI/LO.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int lat, input logic idm,
                          input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; op = o; a = av; b = bv; id_md = idm;
        #1;
        chk({tag, "_stall_start"}, {31'd0, stall}, {31'd0, idm});
        tick();
        start = 1'b0; op = 3'd0;
        for (int i = 1; i <= lat; i++) begin
            chk($sformatf("%s_busy_c%0d", tag, i), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_stall_c%0d", tag, i), {31'd0, stall}, {31'd0, idm});
            chk($sformatf("%s_hold_hi_c%0d", tag, i), hi, m_hi);
            a = $urandom; b = $urandom;
            tick();
        end
        m_hi = eh; m_lo = el;
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; id_md = 1'b0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // mult with id_md held: stall in start cycle and all busy cycles
        run_op("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        // back-to-back multu in the first idle cycle, id_md low
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'd4, 32'd7, 32'd0, 10, 1'b1, 32'd7, 32'hFFFF_FFFF);
        run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000);
        run_op("div0s", 3'd3, 32'hFFFF_FF00, 32'd0, 10, 1'b0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        run_op("divu", 3'd4, 32'd100, 32'd7, 10, 1'b0, 32'd2, 32'd14);

        // mthi then mtlo on consecutive cycles; id_md high must not stall
        start = 1'b1; op = 3'd5; a = 32'h1234_5678; id_md = 1'b1;
        #1;
        chk("mthi_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        op = 3'd6; a = 32'd9;
        tick();
        start = 1'b0; op = 3'd0; id_md = 1'b0;
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_hi", hi, 32'h1234_5678);
        chk("mtlo_lo", lo, 32'd9);
        m_hi = 32'h1234_5678; m_lo = 32'd9;

        // MD_NONE and undefined code 7 have no effect
        start = 1'b1; op = 3'd0; a = 32'hDEAD_BEEF; id_md = 1'b1;
        tick();
        op = 3'd7;
        #1;
        chk("op7_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0; op = 3'd0; id_md = 1'b0;
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_hi", hi, m_hi);
        chk("nop_lo", lo, m_lo);

        // Reset on busy cycle 4 of a divide aborts it
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
        tick();
        start = 1'b0; op = 3'd0;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("abort_busy_c%0d", i), {31'd0, busy}, 32'd1);
            tick();
        end
        chk("abort_busy_c4", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_late_busy", {31'd0, busy}, 32'd0);
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide sequencer for the 5-stage pipeline CPU.
- Accepts an md operation from the EX stage, holds it busy for a fixed latency, then commits the result to HI/LO.
- Supplies mfhi/mflo read data.
- Drives an md-structural stall request into the hazard/forwarding controller, so that any md instruction in ID waits while the unit is occupied.

Parameters:
MULT_LAT, 5, busy cycles for mult/multu (>=1)
DIV_LAT, 10, busy cycles for div/divu (>=1)
CW, 4, counter width; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  EX-stage md instruction valid this cycle
op  in  3  md opcode (def.v: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6)
a  in  32  rs operand (forwarded)
b  in  32  rt operand (forwarded)
id_md  in  1  ID-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  unit occupied
stall  out  1  md-structural stall request to the hazard controller

Behaviour:
- Reset values: hi=0, lo=0, busy=0, stall=0 (with id_md=0). State IDLE, counter=0, pending result cleared.
- Reset mid-operation aborts the operation: the pending result is discarded and HI/LO read 0 after the reset edge.
- States: IDLE and BUSY.
- IDLE:
  - start && op in {MULT, MULTU, DIV, DIVU}: latch the computed 64-bit result into a pending register, load counter with LAT-1, go to BUSY. busy=1 from the next cycle.
  - start && op==MTHI: hi<=a at the edge. op==MTLO: lo<=a. Stay IDLE.
  - start && op==MD_NONE or an undefined code (7): no effect.
- BUSY:
  - Counter decrements each cycle.
  - On the edge where counter==0: {hi,lo}<=pending and go to IDLE.
  - busy is high for exactly LAT cycles; the new HI/LO are visible in the first cycle busy is low.
- Back-to-back: a start in the first IDLE cycle after BUSY is accepted.
- start while BUSY: ignored (state, counter, HI/LO unchanged). The hazard controller guarantees this never occurs; the bench asserts on it.
- stall = id_md && (busy || (start && op in {MULT, MULTU, DIV, DIVU})). Purely combinational; hi/lo are also combinational register outputs.
- Arithmetic:
  - mult: signed 32x32 to 64. multu: unsigned. {hi,lo} = product.
  - div: signed, quotient truncated toward zero; lo=quotient, hi=remainder (sign of dividend).
  - divu: unsigned.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (div or divu): lo=0xFFFFFFFF, hi=a. The unit still goes busy for DIV_LAT cycles.
- mthi/mtlo never set busy and never cause stall on their own.
- Operands are sampled only at the start edge. Later changes on a/b during BUSY have no effect.

Decomposition:
- def.v gains the MD_* opcode constants plus MULT_LAT/DIV_LAT defaults, shared with the controller decoder.
- One combinational sub-module, md_alu (op, a, b -> 64-bit result), containing the signed/unsigned mult/div and the div-by-zero/overflow rules.
- md_sched itself holds the FSM, counter, pending register and HI/LO.

Test Plan:
- Reset, then read: hi=lo=0, busy=0.
- mult a=0xFFFFFFFF, b=2 -> busy high for cycles 1..5 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat with multu -> hi=1, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. divu a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- Hold id_md=1 across start of mult -> stall high in the start cycle and for all 5 busy cycles, low in the cycle HI/LO update. id_md=0 -> stall never high.
- mthi a=0x12345678 then mtlo a=0x9 on consecutive cycles -> hi=0x12345678, lo=9, busy stays 0. Back-to-back mult immediately after busy falls is accepted.
- Start div, assert rst on busy cycle 4 -> next cycle busy=0, hi=lo=0. Pending result is never written.
